// File: rtl/cfs_debounce_if.sv
// Signal bundle between the debouncer and its user: raw input and controls in,
// clean level, change strobe and glitch statistics out.
interface cfs_debounce_if #(
  parameter int GLITCH_W = 8
) ();
  logic                async_in;
  logic                enable;
  logic                glitch_clr;
  logic                data_out;
  logic                changed;
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (
    output async_in, enable, glitch_clr,
    input  data_out, changed, glitch_cnt
  );

  modport slave (
    input  async_in, enable, glitch_clr,
    output data_out, changed, glitch_cnt
  );
endinterface

// File: rtl/cfs_debounce.sv
// Synchroniser plus glitch filter: data_out follows the synchronised input only
// after it has held a new value for STABLE_CYCLES consecutive clocks.
module cfs_debounce #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 4,
  parameter int   CNT_WIDTH     = 4,
  parameter int   GLITCH_W      = 8,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  cfs_debounce_if.slave bus
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_data;
  logic                   r_changed;
  logic [GLITCH_W-1:0]    r_glitch_cnt;

  // NOTE: state is written with <= only, so every flop samples pre-edge values
  // regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.async_in};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_STABLE;
      r_cnt        <= '0;
      r_data       <= RESET_VAL;
      r_changed    <= 1'b0;
      r_glitch_cnt <= '0;
    end else begin
      r_changed <= 1'b0;
      if (bus.glitch_clr) begin
        r_glitch_cnt <= '0;
      end

      if (!bus.enable) begin
        // Bypass: abandon any qualification in progress without counting a glitch.
        r_state   <= ST_STABLE;
        r_cnt     <= '0;
        r_data    <= w_s;
        r_changed <= (w_s != r_data);
      end else begin
        case (r_state)
          ST_STABLE: begin
            if (w_s != r_data) begin
              if (STABLE_CYCLES == 1) begin
                r_data    <= w_s;
                r_changed <= 1'b1;
              end else begin
                r_cnt   <= CNT_WIDTH'(1);
                r_state <= ST_QUALIFY;
              end
            end else begin
              r_cnt <= '0;
            end
          end
          ST_QUALIFY: begin
            if (w_s == r_data) begin
              r_state <= ST_STABLE;
              r_cnt   <= '0;
              // A clear in the same cycle wins over the increment.
              if (!bus.glitch_clr && (r_glitch_cnt != '1)) begin
                r_glitch_cnt <= r_glitch_cnt + 1'b1;
              end
            end else if (r_cnt == LP_LAST) begin
              r_data    <= w_s;
              r_changed <= 1'b1;
              r_cnt     <= '0;
              r_state   <= ST_STABLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.data_out   = r_data;
  assign bus.changed    = r_changed;
  assign bus.glitch_cnt = r_glitch_cnt;

endmodule

// File: tb/tb_cfs_debounce.sv
// Directed bench for cfs_debounce: default build (STABLE_CYCLES=4) plus a
// STABLE_CYCLES=1 build sharing clock and reset.
module tb_cfs_debounce;

  logic clk = 1'b0;
  logic reset;
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  cfs_debounce_if #(.GLITCH_W(8)) bus_a ();
  cfs_debounce_if #(.GLITCH_W(8)) bus_b ();

  cfs_debounce #(
    .SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_WIDTH(4), .GLITCH_W(8), .RESET_VAL(1'b0)
  ) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  cfs_debounce #(
    .SYNC_STAGES(2), .STABLE_CYCLES(1), .CNT_WIDTH(4), .GLITCH_W(8), .RESET_VAL(1'b0)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // High for three synchronised cycles, then low; rejected on the 6th edge.
  task automatic glitch_a(input logic clr_at_detect);
    bus_a.async_in = 1'b1;
    tick(3);
    bus_a.async_in = 1'b0;
    tick(2);
    bus_a.glitch_clr = clr_at_detect;
    tick(1);
    bus_a.glitch_clr = 1'b0;
    tick(1);
  endtask

  logic vv [0:10];

  initial begin
    reset            = 1'b1;
    bus_a.async_in   = 1'b1;
    bus_a.enable     = 1'b1;
    bus_a.glitch_clr = 1'b0;
    bus_b.async_in   = 1'b0;
    bus_b.enable     = 1'b1;
    bus_b.glitch_clr = 1'b0;

    // Reset held with input high
    tick(3);
    check("rst_data", 32'(bus_a.data_out), 0);
    check("rst_changed", 32'(bus_a.changed), 0);
    check("rst_glitch", 32'(bus_a.glitch_cnt), 0);
    reset = 1'b0;
    tick(5);
    check("rel_data_early", 32'(bus_a.data_out), 0);
    tick(1);
    check("rel_data_6", 32'(bus_a.data_out), 1);
    check("rel_changed_6", 32'(bus_a.changed), 1);
    tick(1);
    check("rel_changed_7", 32'(bus_a.changed), 0);

    // Clean 1->0 then 0->1 then 1->0
    bus_a.async_in = 1'b0;
    tick(5);
    check("fall_early", 32'(bus_a.data_out), 1);
    tick(1);
    check("fall_data", 32'(bus_a.data_out), 0);
    check("fall_changed", 32'(bus_a.changed), 1);
    bus_a.async_in = 1'b1;
    tick(5);
    check("rise_changed_off", 32'(bus_a.changed), 0);
    check("rise_early", 32'(bus_a.data_out), 0);
    tick(1);
    check("rise_data", 32'(bus_a.data_out), 1);
    check("rise_changed", 32'(bus_a.changed), 1);
    tick(1);
    check("rise_pulse_end", 32'(bus_a.changed), 0);
    bus_a.async_in = 1'b0;
    tick(8);
    check("settle_low", 32'(bus_a.data_out), 0);
    check("clean_glitch", 32'(bus_a.glitch_cnt), 0);

    // First glitch, watching changed on every cycle
    bus_a.async_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) bus_a.async_in = 1'b0;
      tick(1);
      check("glitch_changed", 32'(bus_a.changed), 0);
      check("glitch_data", 32'(bus_a.data_out), 0);
    end
    check("glitch_cnt1", 32'(bus_a.glitch_cnt), 1);

    // Up to seven, then a glitch colliding with a clear
    for (int i = 0; i < 6; i++) glitch_a(1'b0);
    check("glitch_cnt7", 32'(bus_a.glitch_cnt), 7);
    glitch_a(1'b1);
    check("clr_collision", 32'(bus_a.glitch_cnt), 0);

    // Saturation
    for (int i = 0; i < 300; i++) glitch_a(1'b0);
    check("sat_255", 32'(bus_a.glitch_cnt), 255);
    glitch_a(1'b0);
    check("sat_hold", 32'(bus_a.glitch_cnt), 255);
    bus_a.glitch_clr = 1'b1;
    tick(1);
    bus_a.glitch_clr = 1'b0;
    check("clr_plain", 32'(bus_a.glitch_cnt), 0);

    // Bypass, toggling every 2 cycles: data_out lags the driven value by 2 edges
    vv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bus_a.enable = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      bus_a.async_in = vv[k+2];
      tick(1);
      check("byp_data", 32'(bus_a.data_out), 32'(vv[k]));
      check("byp_changed", 32'(bus_a.changed), 32'(vv[k] ^ vv[k-1]));
    end
    tick(2);
    check("byp_final", 32'(bus_a.data_out), 0);
    check("byp_glitch", 32'(bus_a.glitch_cnt), 0);

    // Drop enable mid-qualification
    bus_a.enable   = 1'b1;
    bus_a.async_in = 1'b1;
    tick(4);
    bus_a.enable = 1'b0;
    tick(1);
    check("drop_data", 32'(bus_a.data_out), 1);
    check("drop_changed", 32'(bus_a.changed), 1);
    check("drop_glitch", 32'(bus_a.glitch_cnt), 0);
    bus_a.enable = 1'b1;
    tick(3);
    check("reen_data", 32'(bus_a.data_out), 1);
    check("reen_changed", 32'(bus_a.changed), 0);
    check("reen_glitch", 32'(bus_a.glitch_cnt), 0);
    bus_a.async_in = 1'b0;
    tick(5);
    check("reen_fall_early", 32'(bus_a.data_out), 1);
    tick(1);
    check("reen_fall", 32'(bus_a.data_out), 0);
    tick(2);

    // Reset at cnt=2 discards the pending change
    bus_a.async_in = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(1);
    check("midrst_data", 32'(bus_a.data_out), 0);
    check("midrst_changed", 32'(bus_a.changed), 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("midrst_hold", 32'(bus_a.data_out), 0);
      check("midrst_nopulse", 32'(bus_a.changed), 0);
    end
    tick(1);
    check("midrst_requal", 32'(bus_a.data_out), 1);
    check("midrst_requal_ch", 32'(bus_a.changed), 1);

    // STABLE_CYCLES=1 build
    check("b_idle", 32'(bus_b.data_out), 0);
    bus_b.async_in = 1'b1;
    tick(2);
    check("b_early", 32'(bus_b.data_out), 0);
    tick(1);
    check("b_rise", 32'(bus_b.data_out), 1);
    check("b_rise_ch", 32'(bus_b.changed), 1);
    tick(1);
    check("b_rise_ch_end", 32'(bus_b.changed), 0);
    bus_b.async_in = 1'b0;
    tick(1);
    bus_b.async_in = 1'b1;
    tick(1);
    tick(1);
    check("b_dip_low", 32'(bus_b.data_out), 0);
    check("b_dip_low_ch", 32'(bus_b.changed), 1);
    tick(1);
    check("b_dip_high", 32'(bus_b.data_out), 1);
    check("b_dip_high_ch", 32'(bus_b.changed), 1);
    tick(2);
    check("b_glitch", 32'(bus_b.glitch_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
